// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: the stream source / observer side; slave: the loader itself.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
   // the source holds in_byte stable while in_valid is high and not yet accepted.
   modport master (
      output in_valid, in_byte,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
   );

   modport slave (
      input  in_valid, in_byte,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a counted, XOR-checksummed byte
// frame, writes them to instruction memory and releases the core on success.
module imem_loader #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   imem_loader_if.slave     bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_CNT_LO = 3'd0,
      S_CNT_HI = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   logic [7:0]  cnt_lo;
   logic [15:0] count;
   logic [15:0] index;
   logic [1:0]  lane;
   logic [23:0] shift;
   logic [7:0]  xsum;
   logic        accept;
   logic [15:0] count_next;

   assign accept     = bus.in_valid && bus.in_ready;
   assign count_next = {bus.in_byte, cnt_lo};
   assign dbg_state  = state;

   // Terminal states and reset are the only times the loader refuses bytes.
   assign bus.in_ready = !rst && (state == S_CNT_LO || state == S_CNT_HI ||
                                  state == S_DATA   || state == S_CSUM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_CNT_LO;
         cnt_lo         <= 8'h00;
         count          <= 16'h0000;
         index          <= 16'h0000;
         lane           <= 2'd0;
         shift          <= 24'h000000;
         xsum           <= 8'h00;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= BASE_ADDR;
         bus.imem_wdata <= 32'h0000_0000;
         bus.cpu_hold   <= 1'b1;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;
         if (accept) begin
            // The checksum byte itself is not folded into the running XOR.
            if (state != S_CSUM) xsum <= xsum ^ bus.in_byte;
            case (state)
               S_CNT_LO: begin
                  cnt_lo <= bus.in_byte;
                  state  <= S_CNT_HI;
               end
               S_CNT_HI: begin
                  count <= count_next;
                  index <= 16'h0000;
                  lane  <= 2'd0;
                  if ({1'b0, count_next} > DEPTH_L) begin
                     state   <= S_ERR;
                     bus.err <= 1'b1;
                  end else if (count_next == 16'h0000) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  lane  <= lane + 2'd1;
                  shift <= {bus.in_byte, shift[23:8]};
                  if (lane == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= {bus.in_byte, shift};
                     bus.imem_addr  <= BASE_ADDR + {14'h0000, index, 2'b00};
                     index          <= index + 16'd1;
                     if ((index + 16'd1) == count) state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  if (bus.in_byte == xsum) begin
                     state        <= S_DONE;
                     bus.done     <= 1'b1;
                     bus.cpu_hold <= 1'b0;
                  end else begin
                     state   <= S_ERR;
                     bus.err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
